// File: rtl/sharpen_core.sv
// rtl/sharpen_core.sv - register-mapped 3x3 sharpening engine producing two clamped pixels
module sharpen_core (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [4:0]  reg_address,
   input  logic [31:0] data_in,
   output logic [31:0] status_out,
   output logic [31:0] result_out,
   output logic [31:0] row1_out,
   output logic [31:0] count_out
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CALC1 = 2'd1;
   localparam logic [1:0] CALC2 = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]  state;
   logic [31:0] row0, row1, row2;
   logic [15:0] result, op_count;
   logic        busy, done, ctrl_wr;
   logic [7:0]  px1, px2;

   // Raw value spans -1020..1275, so 12-bit two's complement wraps exactly; bit 11 is the sign.
   function automatic logic [7:0] sharpen(input logic [7:0] ctr, input logic [7:0] up,
                                          input logic [7:0] dn, input logic [7:0] lf,
                                          input logic [7:0] rt);
      logic [11:0] raw;
      raw = ({4'b0, ctr} << 2) + {4'b0, ctr} - {4'b0, up} - {4'b0, dn}
            - {4'b0, lf} - {4'b0, rt};
      if (raw[11])
         sharpen = 8'd0;
      else if (raw > 12'd255)
         sharpen = 8'd255;
      else
         sharpen = raw[7:0];
   endfunction

   assign px1 = sharpen(row1[15:8], row0[15:8], row2[15:8], row1[7:0], row1[23:16]);
   assign px2 = sharpen(row1[23:16], row0[23:16], row2[23:16], row1[15:8], row1[31:24]);

   assign busy    = (state == CALC1) || (state == CALC2);
   assign done    = (state == DONE);
   assign ctrl_wr = wr_en && (reg_address == 5'd3);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         row0     <= '0;
         row1     <= '0;
         row2     <= '0;
         result   <= '0;
         op_count <= '0;
      end else begin
         // Operands are frozen while a calculation is in flight.
         if (wr_en && !busy) begin
            case (reg_address)
               5'd0:    row0 <= data_in;
               5'd1:    row1 <= data_in;
               5'd2:    row2 <= data_in;
               default: ;
            endcase
         end
         case (state)
            IDLE: begin
               if (ctrl_wr && data_in[0])
                  state <= CALC1;
            end
            CALC1: begin
               result[7:0] <= px1;
               state       <= CALC2;
            end
            CALC2: begin
               result[15:8] <= px2;
               op_count     <= op_count + 16'd1;
               state        <= DONE;
            end
            default: begin
               if (ctrl_wr && data_in[0])
                  state <= CALC1;
               else if (ctrl_wr && data_in[1])
                  state <= IDLE;
            end
         endcase
      end
   end

   assign status_out = {30'b0, done, busy};
   assign result_out = {16'b0, result};
   assign row1_out   = row1;
   assign count_out  = {16'b0, op_count};

endmodule

// File: tb/tb_sharpen_core.sv
// tb/tb_sharpen_core.sv - directed self-checking bench for sharpen_core
module tb_sharpen_core;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_en = 1'b0;
   logic [4:0]  reg_address = '0;
   logic [31:0] data_in = '0;
   logic [31:0] status_out, result_out, row1_out, count_out;

   int total = 0;
   int passed = 0;
   int failed = 0;

   sharpen_core dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .reg_address (reg_address),
      .data_in     (data_in),
      .status_out  (status_out),
      .result_out  (result_out),
      .row1_out    (row1_out),
      .count_out   (count_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; the write is sampled at the next rising edge.
   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      wr_en       = 1'b1;
      reg_address = a;
      data_in     = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      cycles(2);
      chk("reset_status", status_out, 32'h0);
      chk("reset_result", result_out, 32'h0);
      chk("reset_count", count_out, 32'h0);
      reset = 1'b0;
      cycles(1);

      // Flat image
      wr(5'd0, 32'h64646464);
      wr(5'd1, 32'h64646464);
      wr(5'd2, 32'h64646464);
      wr(5'd3, 32'h1);
      chk("flat_busy_t1", status_out, 32'h1);
      cycles(1);
      chk("flat_busy_t2", status_out, 32'h1);
      cycles(1);
      chk("flat_done", status_out, 32'h2);
      chk("flat_result", result_out, 32'h00006464);
      chk("flat_count", count_out, 32'h1);

      // Clamp high (px1 raw 1275) and low (px2 raw -510)
      wr(5'd0, 32'h0);
      wr(5'd2, 32'h0);
      wr(5'd1, 32'hFF00FF00);
      chk("row_write_keeps_done", status_out, 32'h2);
      chk("row_write_keeps_result", result_out, 32'h00006464);
      wr(5'd3, 32'h1);
      cycles(2);
      chk("clamp_result", result_out, 32'h000000FF);
      chk("clamp_count", count_out, 32'h2);

      // Writes during busy are ignored; new ROW1 would give 0x9CFF
      wr(5'd3, 32'h1);
      wr(5'd1, 32'h12345678);
      wr(5'd3, 32'h1);
      chk("busy_done", status_out, 32'h2);
      chk("busy_row1_frozen", row1_out, 32'hFF00FF00);
      chk("busy_result_old", result_out, 32'h000000FF);
      chk("busy_count_once", count_out, 32'h3);

      // Done control
      wr(5'd3, 32'h2);
      chk("clr_done_status", status_out, 32'h0);
      chk("clr_done_result", result_out, 32'h000000FF);
      wr(5'd3, 32'h2);
      chk("clr_in_idle", status_out, 32'h0);
      wr(5'd1, 32'h12345678);
      wr(5'd3, 32'h1);
      cycles(2);
      chk("new_row1_result", result_out, 32'h00009CFF);
      chk("new_row1_count", count_out, 32'h4);
      wr(5'd0, 32'h64646464);
      wr(5'd1, 32'h64646464);
      wr(5'd2, 32'h64646464);
      wr(5'd3, 32'h3);
      chk("start_wins_busy", status_out, 32'h1);
      cycles(2);
      chk("start_wins_done", status_out, 32'h2);
      chk("start_wins_result", result_out, 32'h00006464);
      chk("start_wins_count", count_out, 32'h5);

      // Reset mid-operation, checked before any clock edge
      wr(5'd3, 32'h1);
      chk("pre_reset_busy", status_out, 32'h1);
      reset = 1'b1;
      #1;
      chk("async_status", status_out, 32'h0);
      chk("async_result", result_out, 32'h0);
      chk("async_row1", row1_out, 32'h0);
      chk("async_count", count_out, 32'h0);
      cycles(1);
      reset = 1'b0;
      wr(5'd0, 32'h64646464);
      wr(5'd1, 32'h64646464);
      wr(5'd2, 32'h64646464);
      wr(5'd3, 32'h1);
      cycles(2);
      chk("post_reset_result", result_out, 32'h00006464);
      chk("post_reset_count", count_out, 32'h1);

      // Undecoded addresses and strobeless cycles
      for (int a = 4; a < 32; a++) wr(a[4:0], 32'hFFFFFFFF);
      reg_address = 5'd3;
      data_in     = 32'h1;
      cycles(4);
      reg_address = 5'd1;
      data_in     = 32'hDEADBEEF;
      cycles(2);
      chk("decode_status", status_out, 32'h2);
      chk("decode_row1", row1_out, 32'h64646464);
      chk("decode_result", result_out, 32'h00006464);
      chk("decode_count", count_out, 32'h1);

      // Back-to-back: START accepted in the first DONE cycle
      for (int k = 0; k < 9; k++) begin
         wr(5'd3, 32'h1);
         cycles(2);
      end
      chk("b2b_status", status_out, 32'h2);
      chk("b2b_count", count_out, 32'd10);
      chk("b2b_result", result_out, 32'h00006464);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
